// File: rtl/key_sweep_if.sv
// key_sweep_if -- pattern-offer channel into key_sweep_ctrl.
//
// Handshake: a pattern transfers on a rising clk edge where pat_valid and
// pat_ready are both high. pat_in/exp_in are only meaningful while pat_valid
// is high. The master may hold pat_valid high indefinitely. The slave raises
// pat_ready only while it is able to take a new pattern. Nothing transfers
// when pat_ready is low, whatever the master drives.
//
// Signals:
//   pat_valid  master->slave  a pattern and its oracle response are offered
//   pat_ready  slave->master  the slave accepts a pattern this cycle
//   pat_in     master->slave  input pattern (PI_W)
//   exp_in     master->slave  oracle (unlocked) response to pat_in (PO_W)
interface key_sweep_if #(
  parameter int PI_W = 36,
  parameter int PO_W = 7
);
  logic            pat_valid;
  logic            pat_ready;
  logic [PI_W-1:0] pat_in;
  logic [PO_W-1:0] exp_in;

  modport master (
    output pat_valid,
    output pat_in,
    output exp_in,
    input  pat_ready
  );

  modport slave (
    input  pat_valid,
    input  pat_in,
    input  exp_in,
    output pat_ready
  );
endinterface

// File: rtl/key_sweep_ctrl.sv
// key_sweep_ctrl -- brute-force key elimination for a logic-locked circuit.
//
// Every accepted (pattern, oracle response) pair is applied to the locked
// circuit once for each still-alive candidate key. A candidate whose response
// differs from the oracle is dropped from the alive mask. Dead candidates are
// skipped in a single cycle, so a sweep costs NCAND + A*(SETTLE+1) cycles.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   i_clear       re-arm: every candidate becomes alive again (aborts a sweep)
//   pat_if        pattern-offer channel (slave side)
//   o_dut_pi      pattern driven to the locked circuit
//   o_dut_key     candidate key driven to the locked circuit
//   i_dut_po      locked circuit response
//   o_mask        alive mask, bit k = candidate k still consistent
//   o_alive_cnt   registered popcount of o_mask
//   o_unique      registered, exactly one candidate alive
//   o_key_found   registered, lowest alive candidate index (0 if none)
//   o_none_left   registered, no candidate alive
//   o_busy        a pattern is being swept
//   o_dbg_state   FSM state (0 IDLE, 1 SCAN, 2 HOLD, 3 CHECK)
module key_sweep_ctrl #(
  parameter int PI_W   = 36,
  parameter int PO_W   = 7,
  parameter int KEY_W  = 4,
  parameter int SETTLE = 2,
  localparam int NCAND = 1 << KEY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  key_sweep_if.slave        pat_if,
  output logic [PI_W-1:0]   o_dut_pi,
  output logic [KEY_W-1:0]  o_dut_key,
  input  logic [PO_W-1:0]   i_dut_po,
  output logic [NCAND-1:0]  o_mask,
  output logic [KEY_W:0]    o_alive_cnt,
  output logic              o_unique,
  output logic [KEY_W-1:0]  o_key_found,
  output logic              o_none_left,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam logic [KEY_W-1:0] LAST_IDX  = '1;
  localparam logic [3:0]       HOLD_LOAD = 4'(SETTLE - 1);
  localparam logic [KEY_W:0]   ALL_CNT   = (KEY_W+1)'(NCAND);

  state_t             r_state,  w_state_nxt;
  logic [KEY_W-1:0]   r_idx,    w_idx_nxt;
  logic [3:0]         r_cnt,    w_cnt_nxt;
  logic [NCAND-1:0]   r_mask,   w_mask_nxt;
  logic [PI_W-1:0]    r_pat;
  logic [PO_W-1:0]    r_exp;
  logic               w_load;

  logic [KEY_W:0]     r_alive;
  logic               r_unique;
  logic [KEY_W-1:0]   r_key_found;
  logic               r_none_left;
  logic [KEY_W:0]     w_pop;
  logic [KEY_W-1:0]   w_low;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_mask  <= '1;
      r_pat   <= '0;
      r_exp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mask  <= w_mask_nxt;
      if (w_load) begin
        r_pat <= pat_if.pat_in;
        r_exp <= pat_if.exp_in;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    w_load      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (pat_if.pat_valid) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_mask[r_idx]) begin
          w_cnt_nxt   = HOLD_LOAD;
          w_state_nxt = ST_HOLD;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      ST_HOLD: begin
        // Counter is loaded with SETTLE-1, so HOLD lasts exactly SETTLE cycles.
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      ST_CHECK: begin
        if (i_dut_po != r_exp) begin
          w_mask_nxt[r_idx] = 1'b0;
        end
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt   = r_idx + 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Clear wins over everything except reset: it suppresses acceptance in
    // IDLE and aborts any sweep in flight, including a pending mask update.
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
      w_mask_nxt  = '1;
      w_load      = 1'b0;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
    end
  end

  // Popcount and lowest-set-bit of the mask; registered below so the flags
  // trail the mask by one cycle.
  always_comb begin
    w_pop = '0;
    w_low = '0;
    for (int i = 0; i < NCAND; i++) begin
      w_pop = w_pop + {{KEY_W{1'b0}}, r_mask[i]};
    end
    for (int i = NCAND - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_low = KEY_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alive     <= ALL_CNT;
      r_unique    <= 1'b0;
      r_key_found <= '0;
      r_none_left <= 1'b0;
    end else begin
      r_alive     <= w_pop;
      r_unique    <= (w_pop == (KEY_W+1)'(1));
      r_key_found <= w_low;
      r_none_left <= (w_pop == '0);
    end
  end

  assign pat_if.pat_ready = (r_state == ST_IDLE);
  assign o_busy           = (r_state != ST_IDLE);
  assign o_dut_pi         = r_pat;
  assign o_dut_key        = r_idx;
  assign o_mask           = r_mask;
  assign o_alive_cnt      = r_alive;
  assign o_unique         = r_unique;
  assign o_key_found      = r_key_found;
  assign o_none_left      = r_none_left;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_key_sweep_ctrl.sv
module tb_key_sweep_ctrl;
  localparam int PI_W   = 36;
  localparam int PO_W   = 7;
  localparam int KEY_W  = 4;
  localparam int SETTLE = 2;
  localparam int NCAND  = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_CHECK = 2'd3;

  logic              clk;
  logic              rst;
  logic              clear;
  logic [PI_W-1:0]   dut_pi;
  logic [KEY_W-1:0]  dut_key;
  logic [PO_W-1:0]   dut_po;
  logic [NCAND-1:0]  mask;
  logic [KEY_W:0]    alive_cnt;
  logic              uniq;
  logic [KEY_W-1:0]  key_found;
  logic              none_left;
  logic              busy;
  logic [1:0]        dbg_state;

  int n_checks;
  int n_errors;

  key_sweep_if #(.PI_W(PI_W), .PO_W(PO_W)) pat_if ();

  key_sweep_ctrl #(
    .PI_W(PI_W), .PO_W(PO_W), .KEY_W(KEY_W), .SETTLE(SETTLE)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (clear),
    .pat_if      (pat_if.slave),
    .o_dut_pi    (dut_pi),
    .o_dut_key   (dut_key),
    .i_dut_po    (dut_po),
    .o_mask      (mask),
    .o_alive_cnt (alive_cnt),
    .o_unique    (uniq),
    .o_key_found (key_found),
    .o_none_left (none_left),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oracle function and locked-circuit model: only key 6 reproduces it.
  function automatic logic [PO_W-1:0] oracle(input logic [PI_W-1:0] p);
    return p[6:0] ^ p[35:29] ^ p[20:14];
  endfunction

  always_comb begin
    if (dut_key == 4'd6) dut_po = oracle(dut_pi);
    else                 dut_po = oracle(dut_pi) ^ 7'h01;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: offer one pattern, then follow the sweep until IDLE. Returns
  // the number of busy cycles and the set of keys seen while in HOLD. One
  // extra clock at the end lets the registered flags catch up.
  task automatic run_sweep(input logic [PI_W-1:0] pat, input logic [PO_W-1:0] exp,
                           output int cycles, output logic [NCAND-1:0] hold_keys);
    pat_if.pat_valid = 1'b1;
    pat_if.pat_in    = pat;
    pat_if.exp_in    = exp;
    @(posedge clk); #1;
    pat_if.pat_valid = 1'b0;
    cycles    = 0;
    hold_keys = '0;
    while (busy && cycles < 200) begin
      if (dbg_state == S_HOLD) hold_keys[dut_key] = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    @(posedge clk); #1;
  endtask

  int               cyc;
  logic [NCAND-1:0] hk;
  logic [PI_W-1:0]  p;
  int               accepts;
  int               pi_errs;
  int               busy_cnt;
  logic             cur_ready;
  logic [PI_W-1:0]  cur_pat;
  logic [PI_W-1:0]  acc_pat;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    clear = 1'b0;
    pat_if.pat_valid = 1'b0;
    pat_if.pat_in    = '0;
    pat_if.exp_in    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_ready",     64'(pat_if.pat_ready), 64'd1);
    check("rst_busy",      64'(busy),             64'd0);
    check("rst_mask",      64'(mask),             64'hFFFF);
    check("rst_alive",     64'(alive_cnt),        64'd16);
    check("rst_unique",    64'(uniq),             64'd0);
    check("rst_none_left", 64'(none_left),        64'd0);
    check("rst_key_found", 64'(key_found),        64'd0);
    check("rst_dut_pi",    64'(dut_pi),           64'd0);
    check("rst_dut_key",   64'(dut_key),          64'd0);

    // First pattern with all 16 alive: 16 + 16*3 cycles
    p = 36'h1_2345_6789;
    run_sweep(p, oracle(p), cyc, hk);
    check("p1_latency",   64'(cyc),       64'd64);
    check("p1_hold_keys", 64'(hk),        64'hFFFF);
    check("p1_mask",      64'(mask),      64'h0040);
    check("p1_alive",     64'(alive_cnt), 64'd1);
    check("p1_unique",    64'(uniq),      64'd1);
    check("p1_key_found", 64'(key_found), 64'd6);
    check("p1_none_left", 64'(none_left), 64'd0);

    // Second pattern, only key 6 alive: 16 + 3 cycles
    p = 36'hA_BCDE_F012;
    run_sweep(p, oracle(p), cyc, hk);
    check("p2_latency",   64'(cyc),  64'd19);
    check("p2_hold_keys", 64'(hk),   64'h0040);
    check("p2_mask",      64'(mask), 64'h0040);

    // Oracle response no key can produce
    p = 36'h5_5AA5_33CC;
    run_sweep(p, oracle(p) ^ 7'h40, cyc, hk);
    check("p3_latency",   64'(cyc),       64'd19);
    check("p3_mask",      64'(mask),      64'h0);
    check("p3_alive",     64'(alive_cnt), 64'd0);
    check("p3_none_left", 64'(none_left), 64'd1);
    check("p3_unique",    64'(uniq),      64'd0);
    check("p3_key_found", 64'(key_found), 64'd0);

    // Empty mask: plain 16-cycle walk, flags untouched
    p = 36'h0_0000_FFFF;
    run_sweep(p, oracle(p), cyc, hk);
    check("p4_latency",   64'(cyc),       64'd16);
    check("p4_hold_keys", 64'(hk),        64'h0);
    check("p4_mask",      64'(mask),      64'h0);
    check("p4_none_left", 64'(none_left), 64'd1);

    // clear and pat_valid together in IDLE: clear wins, no acceptance
    clear = 1'b1;
    pat_if.pat_valid = 1'b1;
    @(posedge clk); #1;
    check("clr_idle_busy",  64'(busy),             64'd0);
    check("clr_idle_ready", 64'(pat_if.pat_ready), 64'd1);
    check("clr_idle_mask",  64'(mask),             64'hFFFF);
    clear = 1'b0;
    pat_if.pat_valid = 1'b0;
    @(posedge clk); #1;
    check("clr_idle_alive", 64'(alive_cnt), 64'd16);
    check("clr_idle_none",  64'(none_left), 64'd0);

    // clear while holding candidate 5
    p = 36'h3_3333_4444;
    pat_if.pat_valid = 1'b1;
    pat_if.pat_in    = p;
    pat_if.exp_in    = oracle(p);
    @(posedge clk); #1;
    pat_if.pat_valid = 1'b0;
    cyc = 0;
    while (!(dbg_state == S_HOLD && dut_key == 4'd5) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach_hold5", 64'(cyc < 200), 64'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("abort_state", 64'(dbg_state), 64'(S_IDLE));
    check("abort_mask",  64'(mask),      64'hFFFF);
    busy_cnt = 0;
    @(posedge clk); #1;
    check("abort_alive", 64'(alive_cnt), 64'd16);
    for (int i = 0; i < 6; i++) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
    check("abort_no_replay", 64'(busy_cnt), 64'd0);

    // pat_valid held high with pat_in changing every cycle for 120 edges.
    // Acceptances land on edges 1, 66 (after 64), 86 and 106 (after 19 each).
    accepts = 0;
    pi_errs = 0;
    acc_pat = '0;
    pat_if.pat_valid = 1'b1;
    for (int i = 0; i < 120; i++) begin
      cur_pat = {$urandom_range(15, 0), $urandom};
      pat_if.pat_in = cur_pat;
      pat_if.exp_in = oracle(cur_pat);
      cur_ready = pat_if.pat_ready;
      @(posedge clk); #1;
      if (cur_ready) begin
        accepts++;
        acc_pat = cur_pat;
      end
      if (busy && dut_pi != acc_pat) pi_errs++;
    end
    pat_if.pat_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hold_valid_accepts", 64'(accepts), 64'd4);
    check("hold_valid_pi_errs", 64'(pi_errs), 64'd0);
    check("hold_valid_mask",    64'(mask),    64'h0040);

    // rst in CHECK of key 6 with a mismatching oracle: no mask update
    p = 36'h7_0F0F_0F0F;
    pat_if.pat_valid = 1'b1;
    pat_if.pat_in    = p;
    pat_if.exp_in    = oracle(p) ^ 7'h02;
    @(posedge clk); #1;
    pat_if.pat_valid = 1'b0;
    cyc = 0;
    while (dbg_state != S_CHECK && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_mid_reach_check", 64'(dut_key), 64'd6);
    rst = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear = 1'b0;
    check("rst_mid_busy",    64'(busy),      64'd0);
    check("rst_mid_mask",    64'(mask),      64'hFFFF);
    check("rst_mid_alive",   64'(alive_cnt), 64'd16);
    check("rst_mid_dut_key", 64'(dut_key),   64'd0);
    check("rst_mid_dut_pi",  64'(dut_pi),    64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_sweep_ctrl.md
KEY_SWEEP_CTRL -- requirements
Module: key_sweep_ctrl

Interface
REQ-001 SHALL have parameter PI_W, default 36: width of the locked circuit's primary inputs.
REQ-002 SHALL have parameter PO_W, default 7: width of the locked circuit's primary outputs.
REQ-003 SHALL have parameter KEY_W, default 4: number of key inputs; NCAND = 2^KEY_W candidate keys.
REQ-004 SHALL have parameter SETTLE, default 2, range 1..15: cycles a candidate is held before its outputs are sampled.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 clear  input  1  re-arm: sets every candidate back to alive.
REQ-008 pat_valid  input  1  an input pattern and its oracle response are offered.
REQ-009 pat_ready  output  1  the controller accepts a pattern this cycle.
REQ-010 pat_in  input  PI_W  input pattern.
REQ-011 exp_in  input  PO_W  oracle (unlocked) response to pat_in.
REQ-012 dut_pi  output  PI_W  pattern driven to the locked circuit.
REQ-013 dut_key  output  KEY_W  candidate key driven to the locked circuit.
REQ-014 dut_po  input  PO_W  response of the locked circuit.
REQ-015 mask  output  NCAND  bit k = 1 while candidate key k is consistent with all checked patterns.
REQ-016 alive_cnt  output  KEY_W+1  population count of mask.
REQ-017 unique  output  1  alive_cnt == 1.
REQ-018 key_found  output  KEY_W  index of the lowest set bit of mask; 0 when mask == 0.
REQ-019 none_left  output  1  alive_cnt == 0 (inconsistent oracle data).
REQ-020 busy  output  1  a pattern is being swept.

Function
REQ-021 SHALL implement the FSM states IDLE, SCAN, HOLD and CHECK.
REQ-022 IDLE: pat_ready = 1; when pat_valid is high, SHALL register pat_in/exp_in, set idx = 0 and go to SCAN; otherwise SHALL stay in IDLE.
REQ-023 pat_ready SHALL be 0 in all states other than IDLE, and busy = (state != IDLE).
REQ-024 SCAN: if mask[idx] = 0, SHALL go to SCAN with idx+1, or to IDLE if idx = NCAND-1 (dead candidates cost 1 cycle); if mask[idx] = 1, SHALL load the hold counter to SETTLE-1 and go to HOLD.
REQ-025 HOLD: SHALL decrement the counter and go to CHECK when it reaches 0 (SETTLE cycles in HOLD).
REQ-026 CHECK: SHALL clear mask[idx] if dut_po != registered exp; then SHALL go to IDLE if idx = NCAND-1, else to SCAN with idx+1.
REQ-027 dut_pi SHALL equal the registered pattern and dut_key SHALL equal idx in every state; both SHALL hold their last value in IDLE.
REQ-028 Sweep latency from acceptance to return to IDLE SHALL be NCAND + A*(SETTLE+1) cycles, where A = number of alive candidates at acceptance.
REQ-029 alive_cnt, unique, key_found and none_left SHALL be registered, reflecting mask one cycle after it changes.
REQ-030 clear in IDLE SHALL set mask to all ones, take priority over pat_valid that cycle and leave pat_ready = 1.
REQ-031 clear outside IDLE SHALL abort the sweep, set mask to all ones and return to IDLE next cycle.
REQ-032 A sweep SHALL proceed even when mask = 0, taking NCAND cycles and leaving all flags unchanged.
REQ-033 SHALL ignore pat_valid/pat_in/exp_in changes while not in IDLE.

Reset
REQ-034 On rst, SHALL go to IDLE with mask = all ones, alive_cnt = NCAND, unique = 0, none_left = 0, key_found = 0, idx = 0, dut_pi = 0, dut_key = 0, busy = 0; pat_ready SHALL be 1 from the first cycle after rst is released.
REQ-035 rst asserted mid-sweep SHALL discard the sweep with no mask update that cycle; rst SHALL take priority over clear.

Verification
REQ-036 After reset, with a DUT model whose key 4'b0110 matches the oracle and all other keys mismatch: one pattern -> mask = 16'h0040, alive_cnt = 1, unique = 1, key_found = 6, busy low after 16+16*3 = 64 cycles.
REQ-037 Second pattern with mask = 16'h0040, SETTLE = 2 -> returns to IDLE in 16+3 = 19 cycles; dut_key visits only 6 in HOLD.
REQ-038 Oracle response inconsistent with every key -> mask = 0, none_left = 1, key_found = 0; the next sweep takes exactly 16 cycles.
REQ-039 clear asserted in HOLD of candidate 5 -> IDLE next cycle, mask = 16'hFFFF, alive_cnt = 16; the aborted pattern is not reapplied.
REQ-040 pat_valid held high through a sweep with pat_in changing -> only the pattern present at acceptance is applied; exactly one acceptance per IDLE visit.
